// File: rtl/capture_ctrl.sv
// Purpose: arms on request, skips SKIP_FRAMES whole frames, then forwards one frame of pixel beats to a file writer while checking the frame geometry.
// Latency: one cycle from an accepted input beat to its wr_en/wr_data strobe.
// Backpressure: none on the pixel input; a wr_done from the writer stops the capture early.
module capture_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SKIP_FRAMES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  s_valid,
  input  logic                  s_sof,
  input  logic                  s_eol,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  wr_done,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  cap_done,
  output logic                  frame_err,
  output logic [31:0]           pix_cnt
);

  // Counter widths; the row counter never has to hold IMG_HEIGHT because
  // the last row ends the capture instead of wrapping.
  localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [SW-1:0] SKIP_LOAD = SW'(SKIP_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_SKIP     = 3'd2,
    S_CAPTURE  = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // x/y hold the coordinate the next captured beat is expected to carry
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [SW-1:0] skip_cnt;

  // Per-cycle decode of what the current beat means in the current state
  logic          arm_ok;     // arm accepted from an idle-like state
  logic          first_hit;  // sof beat that becomes pixel (0,0)
  logic          skip_hit;   // sof beat of a frame that is discarded
  logic          cap_err;    // framing violation on a captured beat
  logic          cap_last;   // final pixel of the frame, clean
  logic          cap_stop;   // writer asked us to stop
  logic          do_write;   // beat is forwarded to the writer

  logic          at_x_last;
  logic          at_y_last;
  logic          at_origin;

  assign at_x_last = (x == X_LAST);
  assign at_y_last = (y == Y_LAST);
  assign at_origin = (x == '0) && (y == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; an error outranks completion and writer stop
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (arm_ok) begin
          state_nxt = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF, S_SKIP: begin
        if (first_hit) begin
          state_nxt = S_CAPTURE;
        end else if (skip_hit) begin
          state_nxt = S_SKIP;
        end
      end
      S_CAPTURE: begin
        if (cap_err) begin
          state_nxt = S_ERR;
        end else if (cap_stop || cap_last) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and event decode for the current state and input beat
  always_comb begin
    arm_ok    = 1'b0;
    first_hit = 1'b0;
    skip_hit  = 1'b0;
    cap_err   = 1'b0;
    cap_last  = 1'b0;
    cap_stop  = 1'b0;
    do_write  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        arm_ok = arm;
      end
      S_WAIT_SOF, S_SKIP: begin
        busy = 1'b1;
        // Only frame starts matter while waiting; everything else is dropped
        if (s_valid && s_sof) begin
          if (skip_cnt == '0) begin
            first_hit = 1'b1;
            do_write  = 1'b1;
          end else begin
            skip_hit = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (s_valid) begin
          // eol must coincide exactly with the last column, and sof may
          // only appear on the origin pixel
          cap_err = (s_eol != at_x_last) || (s_sof && !at_origin);
        end
        if (!cap_err) begin
          if (wr_done) begin
            // a beat arriving alongside wr_done is not forwarded
            cap_stop = 1'b1;
          end else if (s_valid) begin
            do_write = 1'b1;
            cap_last = at_x_last && at_y_last;
          end
        end
      end
      default: ;
    endcase
  end

  // Write strobe, data, counters and sticky status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_data   <= '0;
      cap_done  <= 1'b0;
      frame_err <= 1'b0;
      pix_cnt   <= '0;
      x         <= '0;
      y         <= '0;
      skip_cnt  <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_data <= s_data;
        pix_cnt <= pix_cnt + 32'd1;
      end

      // A fresh arm starts a clean capture; results of the last one are
      // held until this point so software can read them
      if (arm_ok) begin
        skip_cnt  <= SKIP_LOAD;
        cap_done  <= 1'b0;
        frame_err <= 1'b0;
        pix_cnt   <= '0;
        x         <= '0;
        y         <= '0;
      end

      if (skip_hit) begin
        skip_cnt <= skip_cnt - SW'(1);
      end

      // Position tracking: the sof beat is column 0, so the next is column 1
      if (first_hit) begin
        x <= XW'(1);
        y <= '0;
      end else if (do_write) begin
        if (at_x_last) begin
          x <= '0;
          if (!at_y_last) begin
            y <= y + YW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
      end

      if (cap_last || cap_stop) begin
        cap_done <= 1'b1;
      end
      if (cap_err) begin
        frame_err <= 1'b1;
      end
    end
  end

  // A capture ends either cleanly or in error, never both
  a_flags_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(cap_done && frame_err));

  // Nothing is ever written once a framing error has been seen
  a_err_silent : assert property (@(posedge clk) disable iff (rst)
    (state == S_ERR) |-> !wr_en);

  // Only the capture path may strobe the writer
  a_write_source : assert property (@(posedge clk) disable iff (rst)
    wr_en |-> ($past(state) inside {S_WAIT_SOF, S_SKIP, S_CAPTURE}));

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: two instances (no skip / skip two frames), 4x2 image.
// Stimulus pushes expected writes into per-instance queues; negedge monitors pop and compare.
// Status flags and counters are checked directly after each directed scenario.
module tb_capture_ctrl;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, arm_a, arm_b;
  logic          s_valid, s_sof, s_eol, wr_done;
  logic [DW-1:0] s_data;

  logic          wr_en_a, busy_a, cap_done_a, frame_err_a;
  logic [DW-1:0] wr_data_a;
  logic [31:0]   pix_cnt_a;
  logic          wr_en_b, busy_b, cap_done_b, frame_err_b;
  logic [DW-1:0] wr_data_b;
  logic [31:0]   pix_cnt_b;

  capture_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(0)) u_a (
    .clk(clk), .rst(rst_a), .arm(arm_a), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol),
    .s_data(s_data), .wr_done(wr_done), .wr_en(wr_en_a), .wr_data(wr_data_a), .busy(busy_a),
    .cap_done(cap_done_a), .frame_err(frame_err_a), .pix_cnt(pix_cnt_a)
  );

  capture_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(2)) u_b (
    .clk(clk), .rst(rst_b), .arm(arm_b), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol),
    .s_data(s_data), .wr_done(wr_done), .wr_en(wr_en_b), .wr_data(wr_data_b), .busy(busy_b),
    .cap_done(cap_done_b), .frame_err(frame_err_b), .pix_cnt(pix_cnt_b)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            pix;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pix_a = 0;
  int   pix_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every write strobe must match the oldest expected write
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (wr_en_a) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_write: got wr_data %0h, expected no write", wr_data_a);
      end else begin
        e = q_a.pop_front();
        chk("a_wr_data", {24'd0, wr_data_a}, {24'd0, e.d});
        chk("a_wr_cycle", cyc, e.cyc);
        chk("a_pix_cnt", pix_cnt_a, e.pix);
        chk("a_cap_done_on_write", {31'd0, cap_done_a}, {31'd0, e.done});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (wr_en_b) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_write: got wr_data %0h, expected no write", wr_data_b);
      end else begin
        e = q_b.pop_front();
        chk("b_wr_data", {24'd0, wr_data_b}, {24'd0, e.d});
        chk("b_wr_cycle", cyc, e.cyc);
        chk("b_pix_cnt", pix_cnt_b, e.pix);
        chk("b_cap_done_on_write", {31'd0, cap_done_b}, {31'd0, e.done});
      end
    end
  end

  // who: 0 = no instance writes this beat, 1 = u_a writes it, 2 = u_b writes it
  task automatic beat(input logic [DW-1:0] d, input logic sof, input logic eol,
                      input int who, input logic last);
    exp_t e;
    s_valid = 1'b1;
    s_sof   = sof;
    s_eol   = eol;
    s_data  = d;
    e.d     = d;
    e.done  = last;
    e.cyc   = cyc + 1;
    if (who == 1) begin
      pix_a++;
      e.pix = pix_a;
      q_a.push_back(e);
    end else if (who == 2) begin
      pix_b++;
      e.pix = pix_b;
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    s_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_arm(input int which);
    if (which == 1) begin arm_a = 1'b1; pix_a = 0; end
    else            begin arm_b = 1'b1; pix_b = 0; end
    @(posedge clk); #1;
    arm_a = 1'b0;
    arm_b = 1'b0;
  endtask

  // One clean 4x2 frame: data base..base+7
  task automatic frame(input logic [DW-1:0] base, input int who);
    for (int i = 0; i < W * H; i++) begin
      beat(base + DW'(i), (i == 0), ((i % W) == W - 1), who, (who != 0) && (i == W * H - 1));
    end
  endtask

  task automatic st_a(input string tag, input logic b, input logic d, input logic e, input int p);
    @(negedge clk);
    chk({tag, "_busy"},      {31'd0, busy_a},      {31'd0, b});
    chk({tag, "_cap_done"},  {31'd0, cap_done_a},  {31'd0, d});
    chk({tag, "_frame_err"}, {31'd0, frame_err_a}, {31'd0, e});
    chk({tag, "_pix_cnt"},   pix_cnt_a,            p);
  endtask

  task automatic st_b(input string tag, input logic b, input logic d, input logic e, input int p);
    @(negedge clk);
    chk({tag, "_busy"},      {31'd0, busy_b},      {31'd0, b});
    chk({tag, "_cap_done"},  {31'd0, cap_done_b},  {31'd0, d});
    chk({tag, "_frame_err"}, {31'd0, frame_err_b}, {31'd0, e});
    chk({tag, "_pix_cnt"},   pix_cnt_b,            p);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_a_pending_writes"}, q_a.size(), 0);
    chk({tag, "_b_pending_writes"}, q_b.size(), 0);
  endtask

  task automatic all_zero_a(input string tag);
    chk({tag, "_wr_en"},   {31'd0, wr_en_a},   32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data_a}, 32'd0);
    st_dummy_zero(tag);
  endtask

  task automatic st_dummy_zero(input string tag);
    chk({tag, "_busy"},      {31'd0, busy_a},      32'd0);
    chk({tag, "_cap_done"},  {31'd0, cap_done_a},  32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err_a}, 32'd0);
    chk({tag, "_pix_cnt"},   pix_cnt_a,            32'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; arm_a = 1'b0; arm_b = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; wr_done = 1'b0;

    // Reset values, with arm held to show reset wins
    arm_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero_a("reset");
    chk("reset_b_busy",   {31'd0, busy_b},  32'd0);
    chk("reset_b_wr_en",  {31'd0, wr_en_b}, 32'd0);
    chk("reset_b_pix",    pix_cnt_b,        32'd0);
    arm_a = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    idle(1);

    // Clean frame 1..8, gap in the middle, arm mid-frame ignored
    do_arm(1);
    st_a("t1_armed", 1'b1, 1'b0, 1'b0, 0);
    beat(8'h55, 1'b0, 1'b0, 0, 1'b0);          // non-sof while waiting: dropped
    beat(8'h01, 1'b1, 1'b0, 1, 1'b0);
    beat(8'h02, 1'b0, 1'b0, 1, 1'b0);
    idle(2);
    beat(8'h03, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h04, 1'b0, 1'b1, 1, 1'b0);
    arm_a = 1'b1;
    beat(8'h05, 1'b0, 1'b0, 1, 1'b0);
    arm_a = 1'b0;
    beat(8'h06, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h07, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h08, 1'b0, 1'b1, 1, 1'b1);
    beat(8'h99, 1'b1, 1'b0, 0, 1'b0);          // after completion: dropped
    st_a("t1_done", 1'b0, 1'b1, 1'b0, 8);
    drain("t1");

    // Early eol at x=2 of row 0
    do_arm(1);
    st_a("t3_armed", 1'b1, 1'b0, 1'b0, 0);
    beat(8'h10, 1'b1, 1'b0, 1, 1'b0);
    beat(8'h11, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h12, 1'b0, 1'b1, 0, 1'b0);
    st_a("t3_err", 1'b0, 1'b0, 1'b1, 2);
    beat(8'h13, 1'b0, 1'b0, 0, 1'b0);
    drain("t3");

    // sof inside the frame at pixel (1,1)
    do_arm(1);
    beat(8'h20, 1'b1, 1'b0, 1, 1'b0);
    beat(8'h21, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h22, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h23, 1'b0, 1'b1, 1, 1'b0);
    beat(8'h24, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h25, 1'b1, 1'b0, 0, 1'b0);
    st_a("t4_err", 1'b0, 1'b0, 1'b1, 5);
    drain("t4");

    // Writer reports done after three writes
    do_arm(1);
    beat(8'h30, 1'b1, 1'b0, 1, 1'b0);
    beat(8'h31, 1'b0, 1'b0, 1, 1'b0);
    beat(8'h32, 1'b0, 1'b0, 1, 1'b0);
    wr_done = 1'b1;
    beat(8'h33, 1'b0, 1'b1, 0, 1'b0);
    wr_done = 1'b0;
    beat(8'h34, 1'b0, 1'b0, 0, 1'b0);
    st_a("t5_stop", 1'b0, 1'b1, 1'b0, 3);
    drain("t5");

    // Reset mid-capture, with arm and a beat in the same cycle
    do_arm(1);
    beat(8'h40, 1'b1, 1'b0, 1, 1'b0);
    beat(8'h41, 1'b0, 1'b0, 1, 1'b0);
    rst_a = 1'b1;
    arm_a = 1'b1;
    beat(8'h42, 1'b0, 1'b0, 0, 1'b0);
    rst_a = 1'b0;
    arm_a = 1'b0;
    @(negedge clk);
    all_zero_a("t6_rst");
    beat(8'h43, 1'b1, 1'b0, 0, 1'b0);          // idle after reset: dropped
    drain("t6");

    // Skip two frames, capture the third
    do_arm(2);
    st_b("t2_armed", 1'b1, 1'b0, 1'b0, 0);
    frame(8'hA0, 0);
    st_b("t2_skipA", 1'b1, 1'b0, 1'b0, 0);
    frame(8'hB0, 0);
    st_b("t2_skipB", 1'b1, 1'b0, 1'b0, 0);
    frame(8'hC0, 2);
    idle(1);
    st_b("t2_done", 1'b0, 1'b1, 1'b0, W * H);
    drain("t2");

    idle(2);
    drain("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
